// File: rtl/cpu_sram_pkg.sv
// Shared types and constants for the CPU SRAM-like port arbiter.
// Holds requester IDs, transfer-size encodings and the request-field bundle.
package cpu_sram_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned STRB_W = 4;

  // Requester IDs stored in the response-routing FIFO
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  // Address-phase fields that travel with a request
  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_bundle_t;

endpackage

// File: rtl/cpu_sram_arbiter_if.sv
// SRAM-like port: address phase (req/addr_ok) and response phase (data_ok/rdata).
// master drives the request fields; slave returns addr_ok, data_ok and rdata.
interface cpu_sram_arbiter_if;
  import cpu_sram_pkg::*;

  logic              req;
  logic              wr;
  logic [SIZE_W-1:0] size;
  logic [STRB_W-1:0] wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/cpu_sram_arbiter_resp_id_fifo.sv
// In-order FIFO of requester IDs for accepted, not-yet-answered transactions.
// Ports: clk, rst_n (async active-low), push/push_data, pop, head, full, empty, count.
// Pushes while full and pops while empty are ignored.
module resp_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Shares one SRAM-like memory port between the fetch (inst) and memory (data) stages.
// Ports: clk, resetn (async active-low), inst/data (slave side of the core ports),
// mem (master toward the bridge), proto_err (sticky: response with nothing outstanding).
// Data wins arbitration unless inst has lost STARVE_LIMIT cycles in a row; responses
// are routed back in issue order through a requester-ID FIFO.
module cpu_sram_arbiter
  import cpu_sram_pkg::*;
#(
  parameter int unsigned OUTSTANDING  = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  cpu_sram_arbiter_if.slave    inst,
  cpu_sram_arbiter_if.slave    data,
  cpu_sram_arbiter_if.master   mem,
  output logic                 proto_err
);

  localparam int unsigned CNT_W    = $clog2(OUTSTANDING) + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                lock_q;
  logic                grant_q;
  logic                grant_c;
  logic [STARVE_W-1:0] starve_q;
  logic                starve_hit;
  logic                sel_req;
  logic                accept;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_head;
  logic [CNT_W-1:0]    fifo_count;
  req_bundle_t         inst_bundle;
  req_bundle_t         data_bundle;
  req_bundle_t         sel_bundle;

  assign starve_hit = (starve_q >= STARVE_W'(STARVE_LIMIT));

  // Arbitration; a locked request keeps its registered grant
  always_comb begin
    grant_c = grant_q;
    if (!lock_q) begin
      if (starve_hit && inst.req) grant_c = ID_INST;
      else if (data.req)          grant_c = ID_DATA;
      else if (inst.req)          grant_c = ID_INST;
    end
  end

  assign inst_bundle = '{wr: inst.wr, size: inst.size, wstrb: inst.wstrb,
                         addr: inst.addr, wdata: inst.wdata};
  assign data_bundle = '{wr: data.wr, size: data.size, wstrb: data.wstrb,
                         addr: data.addr, wdata: data.wdata};
  assign sel_bundle  = (grant_c == ID_DATA) ? data_bundle : inst_bundle;
  assign sel_req     = (grant_c == ID_DATA) ? data.req : inst.req;

  // resetn gates the request so nothing leaks downstream while reset is held
  assign mem.req   = sel_req & ~fifo_full & resetn;
  assign mem.wr    = sel_bundle.wr;
  assign mem.size  = sel_bundle.size;
  assign mem.wstrb = sel_bundle.wstrb;
  assign mem.addr  = sel_bundle.addr;
  assign mem.wdata = sel_bundle.wdata;

  assign accept       = mem.req & mem.addr_ok;
  assign inst.addr_ok = accept & (grant_c == ID_INST);
  assign data.addr_ok = accept & (grant_c == ID_DATA);

  // Responses come back in order; the FIFO head says who asked
  assign pop          = mem.data_ok & ~fifo_empty;
  assign inst.data_ok = pop & (fifo_head == ID_INST);
  assign data.data_ok = pop & (fifo_head == ID_DATA);
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  resp_id_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (1)
  ) u_resp_id_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .push      (accept),
    .push_data (grant_c),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Grant/lock, starvation counter and sticky protocol error
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q    <= 1'b0;
      grant_q   <= ID_DATA;
      starve_q  <= '0;
      proto_err <= 1'b0;
    end else begin
      grant_q <= grant_c;
      // Lock holds even if the requester drops req before acceptance
      if (accept)       lock_q <= 1'b0;
      else if (mem.req) lock_q <= 1'b1;
      if (!inst.req || inst.addr_ok) starve_q <= '0;
      else if (!starve_hit)          starve_q <= starve_q + STARVE_W'(1);
      if (mem.data_ok && fifo_empty) proto_err <= 1'b1;
    end
  end

  occupancy_bound: assert property (@(posedge clk) disable iff (!resetn)
    fifo_count <= CNT_W'(OUTSTANDING));

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed bench for cpu_sram_arbiter: stimulus pushes expected responses into a
// scoreboard; a monitor pops and compares whenever a *_data_ok appears.
module tb_cpu_sram_arbiter;
  import cpu_sram_pkg::*;

  // Memory model returns addr ^ KEY, so 0x1c000100 reads back as 0xdeadbeef
  localparam logic [31:0] KEY = 32'hc2adbfef;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic proto_err;

  cpu_sram_arbiter_if inst_if ();
  cpu_sram_arbiter_if data_if ();
  cpu_sram_arbiter_if mem_if ();

  cpu_sram_arbiter #(
    .OUTSTANDING  (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .inst      (inst_if),
    .data      (data_if),
    .mem       (mem_if),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Downstream memory model: one-cycle response latency, in order
  logic [31:0] pend[$];
  logic        resp_en = 1'b0;
  logic        spur = 1'b0;
  logic        mdl_ok = 1'b0;
  logic [31:0] mdl_rdata = 32'h0;

  assign mem_if.data_ok = mdl_ok | spur;
  assign mem_if.rdata   = mdl_rdata;

  always @(negedge clk) begin
    if (!resetn) pend.delete();
    else begin
      if (mdl_ok && pend.size() > 0) void'(pend.pop_front());
      if (mem_if.req && mem_if.addr_ok) pend.push_back(mem_if.addr);
    end
  end

  always @(posedge clk) begin
    #1;
    mdl_ok    = resetn && resp_en && (pend.size() > 0);
    mdl_rdata = (pend.size() > 0) ? (pend[0] ^ KEY) : 32'h0;
  end

  // Response monitor
  always @(negedge clk) begin
    if (resetn && (inst_if.data_ok || data_if.data_ok)) begin
      if (inst_if.data_ok && data_if.data_ok) begin
        checks++; failures++;
        $display("FAIL both_data_ok: got 2 responses required 1 at %0t", $time);
      end else if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_resp: got data_ok with empty scoreboard at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_id", 32'(data_if.data_ok), 32'(mon_e.id));
        chk("resp_rdata", data_if.data_ok ? data_if.rdata : inst_if.rdata, mon_e.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic id, input logic [31:0] addr);
    exp_t e;
    e.id    = id;
    e.rdata = addr ^ KEY;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        is_inst;
    logic [31:0] ia;
    logic [31:0] da;

    inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = SIZE_WORD;
    inst_if.wstrb = 4'hf; inst_if.addr = 32'h0; inst_if.wdata = 32'h0;
    data_if.req = 1'b1; data_if.wr = 1'b0; data_if.size = SIZE_WORD;
    data_if.wstrb = 4'hf; data_if.addr = 32'h1c000100; data_if.wdata = 32'h0;
    mem_if.addr_ok = 1'b1;
    resp_en = 1'b1;

    // Reset state, with a request pending that must not escape
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_if.req), 32'd0);
    chk("rst_data_addr_ok", 32'(data_if.addr_ok), 32'd0);
    chk("rst_inst_addr_ok", 32'(inst_if.addr_ok), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    data_if.req = 1'b0;
    tick();
    resetn = 1'b1;

    // Single data read
    tick();
    data_if.req = 1'b1; data_if.addr = 32'h1c000100; data_if.size = SIZE_HALF;
    expect_resp(ID_DATA, 32'h1c000100);
    @(negedge clk);
    chk("t1_mem_addr", mem_if.addr, 32'h1c000100);
    chk("t1_mem_size", 32'(mem_if.size), 32'(SIZE_HALF));
    chk("t1_data_addr_ok", 32'(data_if.addr_ok), 32'd1);
    chk("t1_inst_addr_ok", 32'(inst_if.addr_ok), 32'd0);
    tick();
    data_if.req = 1'b0; data_if.size = SIZE_WORD;
    @(negedge clk);
    chk("t1_data_data_ok", 32'(data_if.data_ok), 32'd1);
    chk("t1_inst_data_ok", 32'(inst_if.data_ok), 32'd0);
    chk("t1_data_rdata", data_if.rdata, 32'hdeadbeef);
    drain("t1_drain");

    // Starvation override: inst wins on cycles 8 and 17
    ia = 32'h10000000;
    da = 32'h20000000;
    for (int c = 0; c < 20; c++) begin
      tick();
      inst_if.req = 1'b1; inst_if.addr = ia;
      data_if.req = 1'b1; data_if.addr = da;
      is_inst = (c == 8) || (c == 17);
      expect_resp(is_inst ? ID_INST : ID_DATA, is_inst ? ia : da);
      @(negedge clk);
      chk($sformatf("t2_inst_addr_ok_c%0d", c), 32'(inst_if.addr_ok), 32'(is_inst));
      chk($sformatf("t2_data_addr_ok_c%0d", c), 32'(data_if.addr_ok), 32'(!is_inst));
    end
    tick();
    inst_if.req = 1'b0; data_if.req = 1'b0;
    drain("t2_drain");

    // Lock holds the inst request while data arrives
    ia = 32'h10000040;
    da = 32'h20000040;
    tick();
    mem_if.addr_ok = 1'b0;
    inst_if.req = 1'b1; inst_if.addr = ia;
    expect_resp(ID_INST, ia);
    @(negedge clk);
    chk("t3_c0_mem_req", 32'(mem_if.req), 32'd1);
    chk("t3_c0_mem_addr", mem_if.addr, ia);
    chk("t3_c0_inst_addr_ok", 32'(inst_if.addr_ok), 32'd0);
    tick();
    data_if.req = 1'b1; data_if.addr = da;
    expect_resp(ID_DATA, da);
    @(negedge clk);
    chk("t3_c1_mem_addr", mem_if.addr, ia);
    chk("t3_c1_data_addr_ok", 32'(data_if.addr_ok), 32'd0);
    tick();
    @(negedge clk);
    chk("t3_c2_mem_addr", mem_if.addr, ia);
    tick();
    mem_if.addr_ok = 1'b1;
    @(negedge clk);
    chk("t3_c3_inst_addr_ok", 32'(inst_if.addr_ok), 32'd1);
    chk("t3_c3_mem_addr", mem_if.addr, ia);
    tick();
    inst_if.req = 1'b0;
    @(negedge clk);
    chk("t3_c4_data_addr_ok", 32'(data_if.addr_ok), 32'd1);
    chk("t3_c4_mem_addr", mem_if.addr, da);
    tick();
    data_if.req = 1'b0;
    drain("t3_drain");

    // Fill all four slots (I,D,I,D), then stall, then drain in order
    resp_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      inst_if.req = (k % 2 == 0);
      data_if.req = (k % 2 == 1);
      inst_if.addr = 32'h10000100 + 32'(4 * (k / 2));
      data_if.addr = 32'h20000100 + 32'(4 * (k / 2));
      expect_resp((k % 2 == 1) ? ID_DATA : ID_INST,
                  (k % 2 == 1) ? data_if.addr : inst_if.addr);
      @(negedge clk);
      chk($sformatf("t4_fill_addr_ok_%0d", k),
          32'((k % 2 == 1) ? data_if.addr_ok : inst_if.addr_ok), 32'd1);
    end
    tick();
    inst_if.req = 1'b0;
    data_if.req = 1'b1; data_if.addr = 32'h20000108;
    expect_resp(ID_DATA, 32'h20000108);
    @(negedge clk);
    chk("t4_full_mem_req", 32'(mem_if.req), 32'd0);
    chk("t4_full_data_addr_ok", 32'(data_if.addr_ok), 32'd0);
    tick();
    @(negedge clk);
    chk("t4_full2_mem_req", 32'(mem_if.req), 32'd0);
    resp_en = 1'b1;
    tick();
    @(negedge clk);
    chk("t4_pop_full_mem_req", 32'(mem_if.req), 32'd0);
    chk("t4_pop_full_inst_data_ok", 32'(inst_if.data_ok), 32'd1);
    tick();
    @(negedge clk);
    chk("t4_push_pop_data_addr_ok", 32'(data_if.addr_ok), 32'd1);
    chk("t4_push_pop_data_data_ok", 32'(data_if.data_ok), 32'd1);
    tick();
    data_if.req = 1'b0;
    drain("t4_drain");

    // Spurious response: ignored, sticky proto_err
    tick();
    spur = 1'b1;
    @(negedge clk);
    chk("t6_spur_inst_data_ok", 32'(inst_if.data_ok), 32'd0);
    chk("t6_spur_data_data_ok", 32'(data_if.data_ok), 32'd0);
    tick();
    spur = 1'b0;
    @(negedge clk);
    chk("t6_proto_err_set", 32'(proto_err), 32'd1);
    repeat (3) tick();
    @(negedge clk);
    chk("t6_proto_err_sticky", 32'(proto_err), 32'd1);

    // Async reset with two outstanding transactions
    resp_en = 1'b0;
    tick();
    inst_if.req = 1'b1; inst_if.addr = 32'h10000200;
    @(negedge clk);
    chk("t6_burst_inst_addr_ok", 32'(inst_if.addr_ok), 32'd1);
    tick();
    inst_if.req = 1'b0;
    data_if.req = 1'b1; data_if.addr = 32'h20000200;
    @(negedge clk);
    chk("t6_burst_data_addr_ok", 32'(data_if.addr_ok), 32'd1);
    tick();
    data_if.addr = 32'h20000204;
    #1;
    chk("t6_pre_rst_mem_req", 32'(mem_if.req), 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("t6_async_mem_req", 32'(mem_if.req), 32'd0);
    chk("t6_async_data_addr_ok", 32'(data_if.addr_ok), 32'd0);
    chk("t6_async_proto_err", 32'(proto_err), 32'd0);
    data_if.req = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    resp_en = 1'b1;
    tick();
    spur = 1'b1;
    @(negedge clk);
    chk("t6_post_rst_inst_data_ok", 32'(inst_if.data_ok), 32'd0);
    chk("t6_post_rst_data_data_ok", 32'(data_if.data_ok), 32'd0);
    tick();
    spur = 1'b0;
    @(negedge clk);
    chk("t6_post_rst_proto_err", 32'(proto_err), 32'd1);

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
